charge_port_sched: RTL and testbench

Session scheduler for a multi-port phone charging station. Up to NPORT charging ports share one power supply that can feed at most MAX_ACTIVE ports at once. The block accepts per-port charge requests (time budget in seconds), queues them, and grants supply slots round-robin. It counts down each active port's remaining time on a shared one-second tick and reports completion. It sits between the per-port payment/keypad front ends and the supply switch matrix.

---
 rtl/charge_port_sched.sv | 140 ++++++++++++++
 tb/tb_charge_port_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/charge_port_sched.sv
// charge_port_sched: queues per-port charge requests and grants up to MAX_ACTIVE supply slots round-robin.
// Optional macro PORT0_PRIORITY_EN: a waiting port 0 is granted ahead of the round-robin search.
module charge_port_sched #(
   parameter int NPORT      = 4,
   parameter int MAX_ACTIVE = 2,
   parameter int TICK_DIV   = 25000,
   localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1,
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             load,
   input  logic [PW-1:0]    load_port,
   input  logic [7:0]       load_time,
   input  logic [NPORT-1:0] cancel,
   input  logic [PW-1:0]    rd_port,
   output logic [7:0]       rd_time,
   output logic [NPORT-1:0] pending,
   output logic [NPORT-1:0] active,
   output logic [NPORT-1:0] done,
   output logic [3:0]       n_active,
   output logic             load_err
);

   typedef enum logic [1:0] {IDLE, WAIT, CHARGE} portState_e;

   portState_e       state_q [NPORT];
   portState_e       state_d [NPORT];
   logic [7:0]       time_q  [NPORT];
   logic [7:0]       time_d  [NPORT];
   logic [NPORT-1:0] done_q, done_d;
   logic             loadErr_q, loadErr_d;
   logic [3:0]       nActive_q, nActive_d;
   logic [PW-1:0]    lastGrant_q, lastGrant_d;
   logic [TW-1:0]    tickCnt_q, tickCnt_d;
   logic             tick;

   logic [NPORT-1:0] waitMask;
   logic             grantValid, grantRr;
   logic [PW-1:0]    grantIdx, cand;

   assign tick      = (tickCnt_q == TW'(TICK_DIV - 1));
   assign tickCnt_d = tick ? '0 : tickCnt_q + 1'b1;
   assign done      = done_q;
   assign load_err  = loadErr_q;
   assign n_active  = nActive_q;

   always_comb begin
      pending = '0;
      active  = '0;
      for (int i = 0; i < NPORT; i++) begin
         pending[i] = (state_q[i] == WAIT);
         active[i]  = (state_q[i] == CHARGE);
      end
      rd_time = '0;
      if (int'(rd_port) < NPORT && state_q[rd_port] != IDLE) rd_time = time_q[rd_port];
   end

   // A port cancelled this cycle is not eligible, so the grant goes to the next waiting port instead.
   always_comb begin
      waitMask   = '0;
      grantValid = 1'b0;
      grantRr    = 1'b0;
      grantIdx   = '0;
      cand       = '0;
      for (int i = 0; i < NPORT; i++) waitMask[i] = (state_q[i] == WAIT) && !cancel[i];
      if (nActive_q < 4'(MAX_ACTIVE)) begin
`ifdef PORT0_PRIORITY_EN
         if (waitMask[0]) grantValid = 1'b1;
`else
         grantValid = 1'b0;
`endif
         for (int k = 1; k <= NPORT; k++) begin
            cand = PW'((int'(lastGrant_q) + k) % NPORT);
            if (!grantValid && waitMask[cand]) begin
               grantValid = 1'b1;
               grantRr    = 1'b1;
               grantIdx   = cand;
            end
         end
      end
      lastGrant_d = grantRr ? grantIdx : lastGrant_q;
   end

   // Cancel wins over everything; a port only decrements if it was already charging at cycle start.
   always_comb begin
      done_d    = '0;
      loadErr_d = 1'b0;
      nActive_d = '0;
      for (int i = 0; i < NPORT; i++) begin
         state_d[i] = state_q[i];
         time_d[i]  = time_q[i];
         if (cancel[i]) begin
            state_d[i] = IDLE;
            time_d[i]  = '0;
         end else if (state_q[i] == CHARGE && tick) begin
            time_d[i] = time_q[i] - 8'd1;
            if (time_q[i] == 8'd1) begin
               state_d[i] = IDLE;
               done_d[i]  = 1'b1;
            end
         end else if (grantValid && grantIdx == PW'(i)) begin
            state_d[i] = CHARGE;
         end else if (load && load_port == PW'(i) && state_q[i] == IDLE && load_time != 8'd0) begin
            state_d[i] = WAIT;
            time_d[i]  = load_time;
         end
         nActive_d = nActive_d + 4'(state_d[i] == CHARGE);
      end
      if (load) begin
         if (int'(load_port) >= NPORT) loadErr_d = 1'b1;
         else loadErr_d = (load_time == 8'd0) || (state_q[load_port] != IDLE) || cancel[load_port];
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NPORT; i++) begin
            state_q[i] <= IDLE;
            time_q[i]  <= '0;
         end
         done_q      <= '0;
         loadErr_q   <= 1'b0;
         nActive_q   <= '0;
         lastGrant_q <= PW'(NPORT - 1);
         tickCnt_q   <= '0;
      end else begin
         for (int i = 0; i < NPORT; i++) begin
            state_q[i] <= state_d[i];
            time_q[i]  <= time_d[i];
         end
         done_q      <= done_d;
         loadErr_q   <= loadErr_d;
         nActive_q   <= nActive_d;
         lastGrant_q <= lastGrant_d;
         tickCnt_q   <= tickCnt_d;
      end
   end

endmodule

// File: tb/tb_charge_port_sched.sv
// tb_charge_port_sched: table-driven scoreboard bench for charge_port_sched with a 4-cycle second tick.
module tb_charge_port_sched;

   localparam int NPORT      = 4;
   localparam int MAX_ACTIVE = 2;
   localparam int TICK_DIV   = 4;

   logic       CLK       = 1'b0;
   logic       reset     = 1'b1;
   logic       load      = 1'b0;
   logic [1:0] load_port = '0;
   logic [7:0] load_time = '0;
   logic [3:0] cancel    = '0;
   logic [1:0] rd_port   = '0;
   logic [7:0] rd_time;
   logic [3:0] pending, active, done, n_active;
   logic       load_err;

   int tests    = 0;
   int failures = 0;

   typedef struct {
      logic       ld;
      logic [1:0] lp;
      logic [7:0] lt;
      logic [3:0] cn;
      logic [1:0] rp;
      logic [3:0] pend;
      logic [3:0] act;
      logic [3:0] dn;
      logic [3:0] na;
      logic       le;
      logic [7:0] rt;
   } vec_t;

   vec_t vecs[$];
   vec_t expQ[$];

   charge_port_sched #(.NPORT(NPORT), .MAX_ACTIVE(MAX_ACTIVE), .TICK_DIV(TICK_DIV)) dut (
      .CLK(CLK), .reset(reset), .load(load), .load_port(load_port), .load_time(load_time),
      .cancel(cancel), .rd_port(rd_port), .rd_time(rd_time), .pending(pending),
      .active(active), .done(done), .n_active(n_active), .load_err(load_err)
   );

   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mk(input int ld, lp, lt, cn, rp, pend, act, dn, na, le, rt);
      vec_t v;
      v.ld = 1'(ld);  v.lp = 2'(lp);    v.lt = 8'(lt);   v.cn = 4'(cn);
      v.rp = 2'(rp);  v.pend = 4'(pend); v.act = 4'(act); v.dn = 4'(dn);
      v.na = 4'(na);  v.le = 1'(le);    v.rt = 8'(rt);
      return v;
   endfunction

   task automatic checkField(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      vec_t e;
      if (expQ.size() == 0) begin
         tests++;
         failures++;
         $display("[TB] FAIL %s scoreboard: got 0 entries, expected 1", tag);
         return;
      end
      e = expQ.pop_front();
      checkField({tag, " pending"},  32'(pending),  32'(e.pend));
      checkField({tag, " active"},   32'(active),   32'(e.act));
      checkField({tag, " done"},     32'(done),     32'(e.dn));
      checkField({tag, " n_active"}, 32'(n_active), 32'(e.na));
      checkField({tag, " load_err"}, 32'(load_err), 32'(e.le));
      checkField({tag, " rd_time"},  32'(rd_time),  32'(e.rt));
   endtask

   task automatic applyStimulus(input vec_t v, input string tag);
      load      = v.ld;
      load_port = v.lp;
      load_time = v.lt;
      cancel    = v.cn;
      rd_port   = v.rp;
      expQ.push_back(v);
      @(posedge CLK);
      #1;
      checkOutput(tag);
   endtask

   // Entry i of the table is driven before edge i+1 after reset release.
   task automatic runTable(input string name);
      for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], $sformatf("%s[%0d]", name, i + 1));
      vecs.delete();
   endtask

   task automatic doReset();
      reset     = 1'b1;
      load      = 1'b0;
      load_port = '0;
      load_time = '0;
      cancel    = '0;
      rd_port   = '0;
      @(posedge CLK);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      doReset();
      checkField("reset pending",  32'(pending),  0);
      checkField("reset active",   32'(active),   0);
      checkField("reset done",     32'(done),     0);
      checkField("reset n_active", 32'(n_active), 0);
      checkField("reset load_err", 32'(load_err), 0);
      checkField("reset rd_time",  32'(rd_time),  0);

      // Single session on port 1, three ticks.
      vecs.push_back(mk(1, 1, 3, 0, 1, 'b0010, 0, 0, 0, 0, 3));
      for (int e = 2; e <= 11; e++) vecs.push_back(mk(0, 0, 0, 0, 1, 0, 'b0010, 0, 1, 0, 3 - e / 4));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 'b0010, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      runTable("basic");

      // Two slots busy, third port waits until a slot frees.
      doReset();
      vecs.push_back(mk(1, 0, 2, 0, 0, 'b0001, 0, 0, 0, 0, 2));
      vecs.push_back(mk(1, 1, 2, 0, 0, 'b0010, 'b0001, 0, 1, 0, 2));
      vecs.push_back(mk(1, 2, 2, 0, 2, 'b0100, 'b0011, 0, 2, 0, 2));
      for (int e = 4; e <= 7; e++) vecs.push_back(mk(0, 0, 0, 0, 0, 'b0100, 'b0011, 0, 2, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 2, 'b0100, 0, 'b0011, 0, 0, 2));
      for (int e = 9; e <= 11; e++) vecs.push_back(mk(0, 0, 0, 0, 2, 0, 'b0100, 0, 1, 0, 2));
      for (int e = 12; e <= 15; e++) vecs.push_back(mk(0, 0, 0, 0, 2, 0, 'b0100, 0, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 2, 0, 0, 'b0100, 0, 0, 0));
      runTable("slots");

      // Grant lands on a tick edge: no decrement that cycle.
      doReset();
      vecs.push_back(mk(0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 3, 2, 0, 3, 'b1000, 0, 0, 0, 0, 2));
      for (int e = 4; e <= 7; e++) vecs.push_back(mk(0, 0, 0, 0, 3, 0, 'b1000, 0, 1, 0, 2));
      for (int e = 8; e <= 11; e++) vecs.push_back(mk(0, 0, 0, 0, 3, 0, 'b1000, 0, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 3, 0, 0, 'b1000, 0, 0, 0));
      runTable("tickgrant");

      // Rejected loads.
      doReset();
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(1, 0, 5, 0, 0, 'b0001, 0, 0, 0, 0, 5));
      vecs.push_back(mk(1, 0, 9, 0, 0, 0, 'b0001, 0, 1, 1, 5));
      vecs.push_back(mk(1, 0, 7, 0, 0, 0, 'b0001, 0, 1, 1, 4));
      vecs.push_back(mk(1, 1, 3, 'b0010, 1, 0, 'b0001, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'b0001, 0, 1, 0, 4));
      vecs.push_back(mk(1, 0, 3, 0, 0, 0, 'b0001, 0, 1, 1, 4));
      runTable("errors");

      // Cancel an active port, the waiting port takes the slot next cycle.
      doReset();
      vecs.push_back(mk(1, 0, 5, 0, 0, 'b0001, 0, 0, 0, 0, 5));
      vecs.push_back(mk(1, 1, 5, 0, 0, 'b0010, 'b0001, 0, 1, 0, 5));
      vecs.push_back(mk(1, 2, 5, 0, 0, 'b0100, 'b0011, 0, 2, 0, 5));
      vecs.push_back(mk(0, 0, 0, 0, 0, 'b0100, 'b0011, 0, 2, 0, 4));
      vecs.push_back(mk(0, 0, 0, 'b0001, 0, 'b0100, 'b0010, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 2, 0, 'b0110, 0, 2, 0, 5));
      runTable("cancel");

      reset = 1'b1;
      #1;
      checkField("midreset pending",  32'(pending),  0);
      checkField("midreset active",   32'(active),   0);
      checkField("midreset done",     32'(done),     0);
      checkField("midreset n_active", 32'(n_active), 0);
      checkField("midreset load_err", 32'(load_err), 0);
      checkField("midreset rd_time",  32'(rd_time),  0);
      @(posedge CLK);
      #1;
      checkField("midreset held active", 32'(active), 0);
      reset = 1'b0;

      // Tick phase restarts after reset: first tick on the fourth edge.
      vecs.push_back(mk(1, 1, 1, 0, 1, 'b0010, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 'b0010, 0, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 'b0010, 0, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 'b0010, 0, 0, 0));
      runTable("restart");

      // Keep every port reloaded with one second; grants must rotate 0,1,2,3.
      doReset();
      begin : fairness
         int         grants;
         logic [3:0] prevActive, newBits, idle;
         grants     = 0;
         prevActive = '0;
         for (int cyc = 0; cyc < 100 && grants < 12; cyc++) begin
            idle = ~(pending | active);
            load = (idle != 4'b0000);
            load_time = 8'd1;
            if (idle[0]) load_port = 2'd0;
            else if (idle[1]) load_port = 2'd1;
            else if (idle[2]) load_port = 2'd2;
            else load_port = 2'd3;
            @(posedge CLK);
            #1;
            newBits = active & ~prevActive;
            if (newBits != 4'b0000) begin
               checkField($sformatf("fair grant %0d", grants), 32'(newBits), 32'(1) << (grants % NPORT));
               grants++;
            end
            checkField("fair n_active bound", 32'(n_active > 4'(MAX_ACTIVE)), 0);
            prevActive = active;
         end
         load = 1'b0;
         if (grants < 12) begin
            tests++;
            failures++;
            $display("[TB] FAIL fair budget: got %0d grants, expected 12", grants);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
